// File: rtl/dmem_byte_ctrl.sv
// Byte-serial load/store controller: splits a CPU byte/half/word access into single-byte
// cycles on a byte-wide synchronous memory and reassembles/extends load data.
module dmem_byte_ctrl #(
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StWait,
        StResp
    } state_e;

    state_e state_q, state_d;

    // Request captured at acceptance
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;

    // Transfer progress and load assembly
    logic [1:0]        idx_q;
    logic [31:0]       rbuf_q;
    logic              re_q;
    logic [1:0]        ridx_q;

    logic              accept;
    logic              req_err;
    logic              xfer;
    logic [1:0]        last_idx;
    logic [7:0]        wbyte;

    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_err = 1'b0;
        unique case (req_size)
            2'd0:    req_err = 1'b0;
            2'd1:    req_err = req_addr[0];
            2'd2:    req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        last_idx = 2'd0;
        unique case (size_q)
            2'd1:    last_idx = 2'd1;
            2'd2:    last_idx = 2'd3;
            default: last_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = req_err ? StResp : StXfer;
                end
            end
            StXfer: begin
                if (idx_q == last_idx) begin
                    // Loads need one extra cycle for the last byte to come back
                    state_d = we_q ? StResp : StWait;
                end
            end
            StWait:  state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            idx_q   <= 2'd0;
            rbuf_q  <= 32'd0;
            re_q    <= 1'b0;
            ridx_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            re_q    <= mem_re;
            ridx_q  <= idx_q;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_err;
                idx_q   <= 2'd0;
                rbuf_q  <= 32'd0;
            end else begin
                if (state_q == StXfer) begin
                    idx_q <= idx_q + 2'd1;
                end
                // mem_rdata belongs to the read issued in the previous cycle
                if (re_q) begin
                    unique case (ridx_q)
                        2'd0: rbuf_q[7:0]   <= mem_rdata;
                        2'd1: rbuf_q[15:8]  <= mem_rdata;
                        2'd2: rbuf_q[23:16] <= mem_rdata;
                        2'd3: rbuf_q[31:24] <= mem_rdata;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign xfer = (state_q == StXfer);

    always_comb begin
        wbyte = 8'd0;
        unique case (idx_q)
            2'd0: wbyte = wdata_q[7:0];
            2'd1: wbyte = wdata_q[15:8];
            2'd2: wbyte = wdata_q[23:16];
            2'd3: wbyte = wdata_q[31:24];
            default: wbyte = 8'd0;
        endcase
    end

    assign mem_re    = xfer && !we_q;
    assign mem_we    = xfer && we_q;
    assign mem_addr  = xfer ? (addr_q + ADDR_W'(idx_q)) : '0;
    assign mem_wdata = mem_we ? wbyte : 8'd0;

    assign resp_valid = (state_q == StResp);
    assign resp_err   = resp_valid && err_q;

    always_comb begin
        resp_rdata = 32'd0;
        if (resp_valid && !err_q && !we_q) begin
            unique case (size_q)
                2'd0:    resp_rdata = {{24{!uns_q && rbuf_q[7]}}, rbuf_q[7:0]};
                2'd1:    resp_rdata = {{16{!uns_q && rbuf_q[15]}}, rbuf_q[15:0]};
                default: resp_rdata = rbuf_q;
            endcase
        end
    end

endmodule

// File: doc/dmem_byte_ctrl.md
DMEM_BYTE_CTRL -- requirements
Module: dmem_byte_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 15: byte-address width of the attached byte-wide data memory.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1: CPU access request present.
REQ-005 SHALL have port req_ready, output, 1: controller accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2: access size; 0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-008 SHALL have port req_unsigned, input, 1: on loads, 1 = zero-extend, 0 = sign-extend.
REQ-009 SHALL have port req_addr, input, ADDR_W: byte address of the lowest byte.
REQ-010 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port resp_err, output, 1: completion was misaligned or reserved-size; qualified by resp_valid.
REQ-013 SHALL have port resp_rdata, output, 32: extended load data; qualified by resp_valid.
REQ-014 SHALL have port mem_addr, output, ADDR_W: byte address to memory.
REQ-015 SHALL have port mem_re, output, 1: memory read enable; data returns one cycle later.
REQ-016 SHALL have port mem_we, output, 1: memory write enable.
REQ-017 SHALL have port mem_wdata, output, 8: byte written to memory.
REQ-018 SHALL have port mem_rdata, input, 8: byte read from memory, valid the cycle after mem_re.

Function
REQ-019 SHALL use states IDLE, XFER, WAIT, RESP; req_ready = 1 only in IDLE; a request is accepted at an edge where req_valid & req_ready.
REQ-020 SHALL capture req_we, req_size, req_unsigned, req_addr and req_wdata at acceptance; later input changes have no effect until the next acceptance.
REQ-021 SHALL treat an access as an error when req_size = 3, when req_size = 1 and addr[0] = 1, or when req_size = 2 and addr[1:0] != 0.
REQ-022 SHALL, on an error access, go IDLE->RESP with no mem_re or mem_we, and output resp_valid = 1, resp_err = 1, resp_rdata = 0 in the cycle after acceptance.
REQ-023 SHALL, for a legal access of N bytes (N = 1/2/4), spend N cycles in XFER; in XFER cycle i (i = 0..N-1) it drives mem_addr = base+i, truncated to ADDR_W.
REQ-024 SHALL order bytes little-endian: byte i is data[8i+7:8i].
REQ-025 SHALL, on a store, drive mem_we = 1 and mem_wdata = req_wdata byte i in XFER cycle i; it then enters RESP with resp_valid = 1, resp_err = 0, resp_rdata = 0.
REQ-026 SHALL, on a load, drive mem_re = 1 in XFER cycle i, capture mem_rdata into byte i in the following cycle, pass through one WAIT cycle after the last XFER, then enter RESP.
REQ-027 SHALL, in RESP for a load, present resp_rdata as the N assembled bytes, zero-extended when req_unsigned = 1 and otherwise sign-extended from bit 8N-1.
REQ-028 SHALL hold resp_valid for exactly one cycle in RESP, then return to IDLE; a new request can be accepted at the end of the first IDLE cycle.
REQ-029 SHALL meet these latencies from the acceptance edge to resp_valid: store N+1 cycles, load N+2 cycles, error 1 cycle.
REQ-030 SHALL never assert mem_re and mem_we in the same cycle; both are 0 outside XFER; mem_addr and mem_wdata are 0 when not enabled.

Reset
REQ-031 SHALL, while rst_n = 0 at a clock edge, enter IDLE and drive req_ready = 1 and resp_valid, resp_err, resp_rdata, mem_re, mem_we, mem_addr, mem_wdata = 0.
REQ-032 SHALL, on reset in mid-transfer, abandon the access: no further memory enables after that edge, and no resp_valid for the abandoned access.

Verification
REQ-033 SHALL be verified by: store word 0x8899AABB @0x0010 -> mem_we at 0x10..0x13 with bytes BB, AA, 99, 88 on consecutive cycles; resp_valid 5 cycles after acceptance.
REQ-034 SHALL be verified by: signed load half @0x0010 with memory bytes BB, AA -> resp_rdata = 0xFFFFAABB; unsigned -> 0x0000AABB; resp_valid 4 cycles after acceptance.
REQ-035 SHALL be verified by: signed load byte @0x0013 holding 0x88 -> resp_rdata = 0xFFFFFF88; load word @0x0010 -> 0x8899AABB after 6 cycles.
REQ-036 SHALL be verified by: load word @0x0012, half @0x0011 and size 3 -> for each, resp_err = 1, resp_rdata = 0 after 1 cycle, with no mem_re or mem_we.
REQ-037 SHALL be verified by: store word @0x7FFC -> writes to 0x7FFC..0x7FFF with no address wrap; back-to-back requests held on req_valid -> req_ready is low from acceptance through RESP.
REQ-038 SHALL be verified by: rst_n = 0 during XFER cycle 1 of a word load -> mem_re = 0 from that edge on, no resp_valid, and req_ready = 1.
